// File: rtl/video_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// video_pattern_gen_if
// Stream bundle carried from a video source to the processing chain. It has
// the same shape the HDMI receiver delivers, so the pattern generator can
// stand in for the receiver.
//   dv_o           pixel valid (active area only)
//   hs_o, vs_o     horizontal / vertical sync at their configured polarity
//   r_o, g_o, b_o  8-bit colour, zero whenever dv_o is low
//   frame_start_o  one-cycle pulse on the first active pixel of a frame
// master: the source that drives the stream. slave: the consumer.
// ---------------------------------------------------------------------------
interface video_pattern_gen_if;
    logic       dv_o;
    logic       hs_o;
    logic       vs_o;
    logic [7:0] r_o;
    logic [7:0] g_o;
    logic [7:0] b_o;
    logic       frame_start_o;

    modport master (output dv_o, hs_o, vs_o, r_o, g_o, b_o, frame_start_o);
    modport slave  (input  dv_o, hs_o, vs_o, r_o, g_o, b_o, frame_start_o);
endinterface

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
// Synthetic video source: timing strobes plus one of four test patterns.
//   clk          pixel clock, the only clock
//   rst          asynchronous active-high reset
//   en           synchronous run enable; low restarts the stream at (0,0)
//   pattern_sel  0 bars, 1 grey ramp, 2 checkerboard, 3 animated; this
//                input is sampled only when pixel (0,0) is emitted
//   vid          registered output stream (master side)
// hcnt/vcnt hold the coordinate of the pixel that the next edge emits. All
// outputs come from one register stage, so there is no skew between the
// strobes and the colour.
// ---------------------------------------------------------------------------
module video_pattern_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          pattern_sel,
    video_pattern_gen_if.master vid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [VW-1:0] vcnt, vcnt_nxt;
    logic [7:0]    frame_cnt, frame_cnt_nxt;
    logic [1:0]    pat_q;
    logic [BW-1:0] bar_cnt, bar_cnt_nxt;
    logic [2:0]    bar_idx, bar_idx_nxt;

    logic          h_act, v_act, h_sync, v_sync;
    logic          frame_first, line_last, frame_last;
    logic [1:0]    eff_pat;
    logic [7:0]    x8, y8;
    logic [23:0]   bar_rgb, pix_rgb;

    // Region decode for the pixel about to be emitted. Compared at 32 bits
    // so region bounds equal to H_TOTAL/V_TOTAL never overflow the counters.
    always_comb begin
        h_act       = 32'(hcnt) < H_ACTIVE;
        v_act       = 32'(vcnt) < V_ACTIVE;
        h_sync      = (32'(hcnt) >= H_ACTIVE + H_FP) &&
                      (32'(hcnt) <  H_ACTIVE + H_FP + H_SYNC);
        v_sync      = (32'(vcnt) >= V_ACTIVE + V_FP) &&
                      (32'(vcnt) <  V_ACTIVE + V_FP + V_SYNC);
        frame_first = (hcnt == '0) && (vcnt == '0);
        line_last   = (hcnt == H_LAST);
        frame_last  = line_last && (vcnt == V_LAST);
        // Pixel (0,0) already uses the newly latched pattern.
        eff_pat     = frame_first ? pattern_sel : pat_q;
        // Size casts zero-extend narrow counters and truncate wide ones.
        x8          = 8'(hcnt);
        y8          = 8'(vcnt);
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pix_rgb = 24'h000000;
        case (eff_pat)
            2'd0: pix_rgb = bar_rgb;
            2'd1: pix_rgb = {x8, x8, x8};
            2'd2: pix_rgb = (x8[5] ^ y8[5]) ? 24'hFFFFFF : 24'h000000;
            default: pix_rgb = {frame_cnt, 8'hFF - frame_cnt, y8};
        endcase
    end

    // Counter advance. The bar index steps every BAR_W active pixels and
    // naturally returns to 0 after the 8th bar, so no divider is needed.
    always_comb begin
        hcnt_nxt      = hcnt + 1'b1;
        vcnt_nxt      = vcnt;
        frame_cnt_nxt = frame_cnt;
        bar_cnt_nxt   = bar_cnt;
        bar_idx_nxt   = bar_idx;
        if (line_last) begin
            hcnt_nxt = '0;
            vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
        if (frame_last)
            frame_cnt_nxt = frame_cnt + 8'd1;
        if (line_last) begin
            bar_cnt_nxt = '0;
            bar_idx_nxt = '0;
        end else if (h_act) begin
            if (bar_cnt == BAR_LAST) begin
                bar_cnt_nxt = '0;
                bar_idx_nxt = bar_idx + 3'd1;
            end else begin
                bar_cnt_nxt = bar_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt              <= '0;
            vcnt              <= '0;
            frame_cnt         <= '0;
            pat_q             <= '0;
            bar_cnt           <= '0;
            bar_idx           <= '0;
            vid.dv_o          <= 1'b0;
            vid.hs_o          <= ~HS_POL;
            vid.vs_o          <= ~VS_POL;
            vid.r_o           <= '0;
            vid.g_o           <= '0;
            vid.b_o           <= '0;
            vid.frame_start_o <= 1'b0;
        end else if (!en) begin
            // Stopped: park at (0,0) so re-enable starts a fresh frame.
            hcnt              <= '0;
            vcnt              <= '0;
            frame_cnt         <= '0;
            bar_cnt           <= '0;
            bar_idx           <= '0;
            vid.dv_o          <= 1'b0;
            vid.hs_o          <= ~HS_POL;
            vid.vs_o          <= ~VS_POL;
            vid.r_o           <= '0;
            vid.g_o           <= '0;
            vid.b_o           <= '0;
            vid.frame_start_o <= 1'b0;
        end else begin
            hcnt              <= hcnt_nxt;
            vcnt              <= vcnt_nxt;
            frame_cnt         <= frame_cnt_nxt;
            bar_cnt           <= bar_cnt_nxt;
            bar_idx           <= bar_idx_nxt;
            if (frame_first)
                pat_q <= pattern_sel;
            vid.dv_o          <= h_act && v_act;
            vid.hs_o          <= h_sync ? HS_POL : ~HS_POL;
            vid.vs_o          <= v_sync ? VS_POL : ~VS_POL;
            vid.r_o           <= (h_act && v_act) ? pix_rgb[23:16] : 8'h00;
            vid.g_o           <= (h_act && v_act) ? pix_rgb[15:8]  : 8'h00;
            vid.b_o           <= (h_act && v_act) ? pix_rgb[7:0]   : 8'h00;
            vid.frame_start_o <= frame_first;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
// Directed bench on a 25x8 raster. Observed stream is packed as
// {dv, hs, vs, frame_start, r, g, b} (28 bits) and compared with a
// reference raster walker that tracks position, frame number and latched
// pattern; key points also get hand-computed constants.
// ---------------------------------------------------------------------------
module tb_video_pattern_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 8

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                                          24'h00FF00, 24'hFF00FF, 24'hFF0000,
                                          24'h0000FF, 24'h000000};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] pattern_sel;

    video_pattern_gen_if vid ();

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pattern_sel(pattern_sel),
        .vid(vid)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference walker state: next pixel (mx,my), frame count, latched pattern.
    int mx, my, mfc, mpat;
    int cyc_since_fs;
    bit fs_seen;

    function automatic logic [27:0] obs();
        return {vid.dv_o, vid.hs_o, vid.vs_o, vid.frame_start_o,
                vid.r_o, vid.g_o, vid.b_o};
    endfunction

    task automatic chk(input string tag, input logic [27:0] o, input logic [27:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [27:0] exp_pix(input int x, input int y, input int pat, input int fc);
        logic dv, hs, vs, fs;
        logic [23:0] rgb;
        logic [7:0] x8, y8, f8;
        x8  = 8'(x);
        y8  = 8'(y);
        f8  = 8'(fc);
        dv  = (x < HA) && (y < VA);
        hs  = (x >= HA + HF) && (x < HA + HF + HS);
        vs  = (y >= VA + VF) && (y < VA + VF + VS);
        fs  = (x == 0) && (y == 0);
        rgb = 24'h0;
        if (dv) begin
            case (pat)
                0: rgb = BARS[x / (HA / 8)];
                1: rgb = {x8, x8, x8};
                2: rgb = (((x / 32) ^ (y / 32)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
                default: rgb = {f8, 8'hFF - f8, y8};
            endcase
        end
        return {dv, hs, vs, fs, rgb};
    endfunction

    task automatic model_restart();
        mx = 0; my = 0; mfc = 0;
        fs_seen = 1'b0;
        cyc_since_fs = 0;
    endtask

    // One clock with en=1: check the emitted pixel, then advance the walker.
    task automatic step();
        int sel;
        bit last;
        sel = int'(pattern_sel);
        @(posedge clk);
        #1;
        if (mx == 0 && my == 0) mpat = sel;
        chk($sformatf("pix(%0d,%0d) f%0d", mx, my, mfc), obs(), exp_pix(mx, my, mpat, mfc));
        cyc_since_fs++;
        if (vid.frame_start_o) begin
            if (fs_seen) chk("fs_spacing", 28'(cyc_since_fs), 28'd200);
            fs_seen = 1'b1;
            cyc_since_fs = 0;
        end
        last = (mx == HT - 1) && (my == VT - 1);
        mx++;
        if (mx == HT) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end
        if (last) mfc = (mfc + 1) % 256;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        pattern_sel = 2'd0;
        mpat = 0;
        model_restart();

        // Reset values and first pixel.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", obs(), 28'h0000000);
        rst = 1'b0;
        step();
        chk("first_pixel", obs(), 28'h9FFFFFF);

        // Colour bars and blanking.
        run(2);
        chk("bar_x2", obs(), 28'h8FFFF00);
        run(8);
        chk("bar_x10", obs(), 28'h8FF0000);
        run(4);
        chk("bar_x14", obs(), 28'h8000000);
        run(4);
        chk("hblank_hs_x18", obs(), 28'h4000000);

        // Rest of three frames of geometry (pixels 19..599).
        run(581);

        // Pattern latch: switch to ramp at line 2 of frame 3.
        run(51);
        pattern_sel = 2'd1;
        run(149);
        run(6);
        chk("ramp_x5", obs(), 28'h8050505);
        pattern_sel = 2'd3;
        run(194);
        run(1);
        chk("anim_frame5", obs(), 28'h905FA00);

        // Animated pattern across the frame counter wrap.
        run(199 + 249 * 200);
        run(1);
        chk("anim_frame255", obs(), 28'h9FF0000);
        run(199);
        run(1);
        chk("anim_frame256_wrap", obs(), 28'h900FF00);

        // en deasserted while the next pixel is (7,2).
        run(56);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("en_low_%0d", i), obs(), 28'h0000000);
        end
        en = 1'b1;
        model_restart();
        step();
        chk("en_restart", obs(), 28'h900FF00);
        run(50);

        // Asynchronous reset between edges.
        pattern_sel = 2'd0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_immediate", obs(), 28'h0000000);
        @(posedge clk);
        #1;
        chk("async_rst_held", obs(), 28'h0000000);
        rst = 1'b0;
        model_restart();
        step();
        chk("post_rst_first", obs(), 28'h9FFFFFF);
        run(599);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

- Generates a complete synthetic video stream: pixel-valid and sync strobes plus 8-bit RGB.
- Its output uses the same stream format the HDMI receiver delivers to the processing chain: `dv`, `hs`, `vs`, `r`, `g`, `b`.
- It can therefore replace the receiver as the source for the Y conversion, the FIR filter and the HDMI transmitter. This is useful for bring-up without a video source and as a reference stimulus for the filter.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line; must be a multiple of 8.
- H_FP, 110, horizontal front porch, in pixels.
- H_SYNC, 40, horizontal sync width, in pixels.
- H_BP, 220, horizontal back porch, in pixels.
- V_ACTIVE, 720, active lines per frame.
- V_FP, 5, vertical front porch, in lines.
- V_SYNC, 5, vertical sync width, in lines.
- V_BP, 20, vertical back porch, in lines.
- HS_POL, 1, asserted level of hs_o.
- VS_POL, 1, asserted level of vs_o.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; synchronous.
- pattern_sel  in  2  pattern select; sampled only at frame start.
- dv_o  out  1  pixel valid; high only inside the active area.
- hs_o  out  1  horizontal sync.
- vs_o  out  1  vertical sync.
- r_o, g_o, b_o  out  8 each  pixel colour; 0 whenever dv_o=0.
- frame_start_o  out  1  one-cycle pulse on the first active pixel of each frame.

## Operation
- **Counters:** hcnt runs 0..H_TOTAL-1 and vcnt runs 0..V_TOTAL-1.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Each counter holds the coordinate of the pixel to be emitted on the next clock edge.
  - hcnt wraps H_TOTAL-1 → 0 and increments vcnt on that wrap. vcnt wraps V_TOTAL-1 → 0 (end of frame).
- **Region order** (both axes): active, front porch, sync, back porch.
  - Active: hcnt < H_ACTIVE.
  - Horizontal sync: H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
  - Vertical regions use vcnt the same way. vs_o is asserted for entire lines, so it changes only at hcnt = 0.
- **Strobes:**
  - dv_o = 1 when (h active AND v active).
  - hs_o = HS_POL during the h-sync region, otherwise ~HS_POL.
  - vs_o = VS_POL during the v-sync lines, otherwise ~VS_POL.
- **Pattern latch:** pattern_sel is latched into pat_q when (hcnt,vcnt) = (0,0) is emitted. A change mid-frame takes effect on the next frame only.
- **Frame counter:** frame_cnt is 8 bits, increments after the last pixel of each frame, and wraps 255 → 0.
- **Patterns** (x = hcnt, y = vcnt, for the pixel being emitted):
  - **0, colour bars:** 8 bars, each H_ACTIVE/8 wide. Use a bar index counter, not a divider.
    - Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - **1, grey ramp:** r = g = b = x[7:0].
  - **2, checkerboard:** 32×32 cells. r = g = b = (x[5]^y[5]) ? FF : 00.
  - **3, animated:** r = frame_cnt, g = 8'hFF - frame_cnt, b = y[7:0].
- **en = 0:**
  - Synchronously clears hcnt, vcnt and frame_cnt.
  - Forces all outputs to their reset values on the next edge.
  - When en returns high, the stream restarts at pixel (0,0) and pattern_sel is re-latched.
- **rst:** asynchronously clears all state at any time; no partial frame is completed.

## Timing
- Reset values:
  - dv_o = 0, hs_o = ~HS_POL, vs_o = ~VS_POL.
  - r_o = g_o = b_o = 0, frame_start_o = 0.
  - hcnt = vcnt = 0, frame_cnt = 0, pat_q = 0.
- All outputs are registered and mutually aligned, with no skew between dv/hs/vs and RGB.
- The first rising edge with rst = 0 and en = 1 puts pixel (0,0) on the outputs, with dv_o = 1 and frame_start_o = 1.
- One pixel per clock, with no stalls.
- Line period is exactly H_TOTAL cycles; frame period is exactly H_TOTAL×V_TOTAL cycles.
- frame_start_o is high for exactly 1 cycle per frame, coincident with dv_o at (0,0).
- Latency from an en deassert to reset-valued outputs is 1 edge.

## Test plan
Small-parameter bench: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=4 (H_TOTAL=25); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8).

1. **Reset values and first pixel:** hold rst high, then release with en = 1.
   - During reset, all outputs show their reset values.
   - After the first edge: dv_o = 1 and frame_start_o = 1; with pattern_sel = 0, RGB = FFFFFF.
2. **Frame geometry:** run 3 frames.
   - Per line: dv_o high for 16 cycles, then low for 9; hs_o = HS_POL exactly on cycles 18–20 of each line.
   - vs_o asserted for lines 5–6 only.
   - frame_start_o spacing is exactly 200 cycles.
3. **Colour bars:** pattern_sel = 0.
   - Pixels 0–1 = FFFFFF, 2–3 = FFFF00, 10–11 = FF0000, 14–15 = 000000.
   - RGB = 0 in blanking.
4. **Pattern latch:** switch pattern_sel 0→1 at line 2.
   - The current frame stays bars.
   - The next frame shows the ramp: pixel x = 5 has r = g = b = 05.
   - Pattern 3: r increments by 1 per frame and wraps from FF to 00 after 256 frames.
5. **en deassert mid-line:** drop en at hcnt = 7, vcnt = 2 for 4 cycles, then re-raise.
   - Outputs go to reset values 1 edge after the drop.
   - On restart, pixel (0,0) is emitted with frame_start_o = 1.
6. **Asynchronous reset mid-frame:** assert rst between clock edges.
   - Outputs clear immediately, without waiting for a clock edge.
   - After release, geometry checks from scenario 2 pass again from (0,0).
